apb_mtimer: RTL and testbench



---
 rtl/apb_mtimer_pkg.sv | 32 +++
 rtl/mtimer_prescaler.sv | 32 +++
 rtl/apb_mtimer.sv | 132 +++++++++++++
 tb/tb_apb_mtimer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/apb_mtimer_pkg.sv
// Shared constants and helpers for the APB machine timer: register offsets,
// control layout, reset values and byte-strobe merging.
package apb_mtimer_pkg;

  localparam logic [2:0] MtimeLoOffs    = 3'd0;
  localparam logic [2:0] MtimeHiOffs    = 3'd1;
  localparam logic [2:0] MtimecmpLoOffs = 3'd2;
  localparam logic [2:0] MtimecmpHiOffs = 3'd3;
  localparam logic [2:0] MtimerCtrlOffs = 3'd4;

  localparam logic [63:0] MtimecmpRst = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int unsigned MtimerPrescWidth = 8;

  typedef struct packed {
    logic [MtimerPrescWidth-1:0] presc;
    logic                        en;
  } mtimer_ctrl_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
      else         res[8*k +: 8] = old_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for mtime: emits a one-cycle tick every PRESC+1 enabled cycles.
module mtimer_prescaler import apb_mtimer_pkg::*; #(
  parameter int unsigned PrescWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PrescWidth-1:0] presc,
  output logic                  tick
);

  logic [PrescWidth-1:0] cnt;
  logic                  at_limit;

  // >= rather than == so a PRESC lowered below the running count still wraps promptly
  assign at_limit = (cnt >= presc);
  assign tick     = en & at_limit;

  // Prescale counter, held at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (at_limit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {{(PrescWidth-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/apb_mtimer.sv
// APB machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and a
// registered level timer interrupt. Zero-wait-state 32-bit APB slave.
module apb_mtimer import apb_mtimer_pkg::*; #(
  parameter int unsigned PrescWidth = 8,
  parameter int unsigned AddrWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [31:0]          pwdata_i,
  input  logic [3:0]           pstrb_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 irq_timer_o
);

  logic                  access;
  logic                  wr;
  logic                  rd;
  logic [2:0]            offs;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [31:0]           hi_shadow;
  logic                  en;
  logic [PrescWidth-1:0] presc;
  logic                  tick;
  logic                  irq;
  logic [31:0]           ctrl_rd;
  logic [31:0]           ctrl_new;
  logic                  unused_addr;

  assign access      = psel_i & penable_i;
  assign wr          = access & pwrite_i;
  assign rd          = access & ~pwrite_i;
  assign offs        = paddr_i[4:2];
  assign unused_addr = ^{paddr_i[AddrWidth-1:5], paddr_i[1:0]};
  assign pready_o    = 1'b1;
  assign irq_timer_o = irq;

  mtimer_prescaler #(.PrescWidth(PrescWidth)) u_prescaler (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (en),
    .presc (presc),
    .tick  (tick)
  );

  // CTRL image as seen by software; reserved bits read zero
  always_comb begin
    ctrl_rd                  = 32'd0;
    ctrl_rd[0]               = en;
    ctrl_rd[8 +: PrescWidth] = presc;
    ctrl_new                 = strb_merge(ctrl_rd, pwdata_i, pstrb_i);
  end

  // Combinational read mux and error decode
  always_comb begin
    prdata_o  = 32'd0;
    pslverr_o = 1'b0;
    if (access) begin
      case (offs)
        MtimeLoOffs:    prdata_o = pwrite_i ? 32'd0 : mtime[31:0];
        MtimeHiOffs:    prdata_o = pwrite_i ? 32'd0 : hi_shadow;
        MtimecmpLoOffs: prdata_o = pwrite_i ? 32'd0 : mtimecmp[31:0];
        MtimecmpHiOffs: prdata_o = pwrite_i ? 32'd0 : mtimecmp[63:32];
        MtimerCtrlOffs: prdata_o = pwrite_i ? 32'd0 : ctrl_rd;
        default:        pslverr_o = 1'b1;
      endcase
    end else begin
      prdata_o  = 32'd0;
      pslverr_o = 1'b0;
    end
  end

  // mtime: a write to either half wins over the tick and suppresses the carry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime <= 64'd0;
    end else if (wr && offs == MtimeLoOffs) begin
      mtime[31:0] <= strb_merge(mtime[31:0], pwdata_i, pstrb_i);
    end else if (wr && offs == MtimeHiOffs) begin
      mtime[63:32] <= strb_merge(mtime[63:32], pwdata_i, pstrb_i);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // High-half shadow captured on a LO read so LO-then-HI is coherent
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_shadow <= 32'd0;
    end else if (rd && offs == MtimeLoOffs) begin
      hi_shadow <= mtime[63:32];
    end
  end

  // mtimecmp register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp <= MtimecmpRst;
    end else if (wr && offs == MtimecmpLoOffs) begin
      mtimecmp[31:0] <= strb_merge(mtimecmp[31:0], pwdata_i, pstrb_i);
    end else if (wr && offs == MtimecmpHiOffs) begin
      mtimecmp[63:32] <= strb_merge(mtimecmp[63:32], pwdata_i, pstrb_i);
    end
  end

  // CTRL register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en    <= 1'b0;
      presc <= '0;
    end else if (wr && offs == MtimerCtrlOffs) begin
      en    <= ctrl_new[0];
      presc <= ctrl_new[8 +: PrescWidth];
    end
  end

  // Level interrupt, recomputed every cycle regardless of EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq <= 1'b0;
    end else begin
      irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_apb_mtimer.sv
// Scoreboard bench for apb_mtimer: APB tasks push expected responses, a
// negedge monitor pops and compares them; interrupt timing checked directly.
module tb_apb_mtimer;

  logic        clk;
  logic        rst;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  apb_mtimer #(.PrescWidth(8), .AddrWidth(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .paddr_i     (paddr),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .pwdata_i    (pwdata),
    .pstrb_i     (pstrb),
    .prdata_o    (prdata),
    .pready_o    (pready),
    .pslverr_o   (pslverr),
    .irq_timer_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every access cycle pops one expected response
  always @(negedge clk) begin
    if (psel && penable) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_access: got prdata=%h pslverr=%b with empty scoreboard", prdata, pslverr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        if ((e.chk_data && prdata !== e.data) || pslverr !== e.err || pready !== 1'b1) begin
          failed++;
          $display("FAIL %s: got prdata=%h pslverr=%b pready=%b, expected prdata=%h pslverr=%b",
                   e.name, prdata, pslverr, pready, e.data, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apb(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] exp_data,
                     input logic exp_err, input string name);
    exp_t e;
    @(posedge clk); #1;
    paddr = addr; pwrite = w; pwdata = wdata; pstrb = strb;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    e.data = exp_data; e.err = exp_err; e.chk_data = ~w; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic err, input string name);
    apb(1'b1, addr, data, strb, 32'd0, err, name);
  endtask

  task automatic rd32(input logic [31:0] addr, input logic [31:0] exp,
                      input logic err, input string name);
    apb(1'b0, addr, 32'd0, 4'hF, exp, err, name);
  endtask

  initial begin
    rst = 1'b1; paddr = 32'd0; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = 32'd0; pstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("idle_prdata", prdata, 32'd0);
    chk("idle_pslverr", {31'd0, pslverr}, 32'd0);
    rd32(32'h00, 32'h0000_0000, 1'b0, "rst_mtime_lo");
    rd32(32'h04, 32'h0000_0000, 1'b0, "rst_mtime_hi");
    rd32(32'h08, 32'hFFFF_FFFF, 1'b0, "rst_cmp_lo");
    rd32(32'h0C, 32'hFFFF_FFFF, 1'b0, "rst_cmp_hi");
    rd32(32'h10, 32'h0000_0000, 1'b0, "rst_ctrl");

    // PRESC=3: one tick every 4 cycles, read sampled 42 cycles after enable
    wr32(32'h10, 32'h0000_0301, 4'hF, 1'b0, "wr_ctrl_presc3");
    repeat (40) @(posedge clk);
    rd32(32'h00, 32'd10, 1'b0, "presc3_mtime_lo");
    rd32(32'h10, 32'h0000_0301, 1'b0, "ctrl_readback");

    // Carry into HI and shadow coherence, PRESC=0
    wr32(32'h10, 32'h0000_0000, 4'hF, 1'b0, "stop");
    wr32(32'h04, 32'h0000_0000, 4'hF, 1'b0, "wr_hi0");
    wr32(32'h00, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr_lo_ffff");
    wr32(32'h10, 32'h0000_0001, 4'hF, 1'b0, "run_presc0");
    rd32(32'h00, 32'h0000_0001, 1'b0, "carry_lo");
    wr32(32'h04, 32'h0000_0007, 4'hF, 1'b0, "wr_hi7_running");
    rd32(32'h04, 32'h0000_0001, 1'b0, "shadow_hi");
    rd32(32'h00, 32'h0000_0009, 1'b0, "lo_after_hi_write");
    rd32(32'h04, 32'h0000_0007, 1'b0, "shadow_hi_new");
    wr32(32'h10, 32'h0000_0000, 4'hF, 1'b0, "stop2");

    // Interrupt timing
    wr32(32'h04, 32'h0000_0000, 4'hF, 1'b0, "clr_hi");
    wr32(32'h00, 32'h0000_0000, 4'hF, 1'b0, "clr_lo");
    wr32(32'h0C, 32'h0000_0000, 4'hF, 1'b0, "cmp_hi0");
    wr32(32'h08, 32'd20, 4'hF, 1'b0, "cmp_lo20");
    chk("irq_before_run", {31'd0, irq}, 32'd0);
    wr32(32'h10, 32'h0000_0001, 4'hF, 1'b0, "run_irq");
    repeat (20) @(posedge clk);
    #1 chk("irq_at_mtime20", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 chk("irq_rise", {31'd0, irq}, 32'd1);
    wr32(32'h08, 32'hFFFF_FFFF, 4'hF, 1'b0, "cmp_lo_raise");
    chk("irq_still_high", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1 chk("irq_cleared", {31'd0, irq}, 32'd0);
    wr32(32'h10, 32'h0000_0000, 4'hF, 1'b0, "stop3");

    // Byte strobes, reserved CTRL bits, invalid offset
    wr32(32'h00, 32'h1122_3344, 4'hF, 1'b0, "wr_lo_full");
    wr32(32'h00, 32'hAABB_CCDD, 4'b0101, 1'b0, "wr_lo_strb");
    rd32(32'h00, 32'h11BB_33DD, 1'b0, "strb_merge");
    wr32(32'h10, 32'hFFFF_FFFE, 4'hF, 1'b0, "ctrl_reserved");
    rd32(32'h10, 32'h0000_FF00, 1'b0, "ctrl_reserved_rd");
    wr32(32'h14, 32'hDEAD_BEEF, 4'hF, 1'b1, "wr_invalid");
    rd32(32'h14, 32'h0000_0000, 1'b1, "rd_invalid");
    rd32(32'h00, 32'h11BB_33DD, 1'b0, "no_change_lo");
    rd32(32'h08, 32'hFFFF_FFFF, 1'b0, "no_change_cmp");

    // Asynchronous reset with irq high
    wr32(32'h0C, 32'h0000_0000, 4'hF, 1'b0, "cmp_hi_zero");
    wr32(32'h08, 32'h0000_0000, 4'hF, 1'b0, "cmp_lo_zero");
    wr32(32'h10, 32'h0000_0001, 4'hF, 1'b0, "run_again");
    repeat (5) @(posedge clk);
    #1 chk("irq_high_pre_rst", {31'd0, irq}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("irq_async_clear", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd32(32'h00, 32'h0000_0000, 1'b0, "post_rst_lo");
    rd32(32'h04, 32'h0000_0000, 1'b0, "post_rst_hi");
    rd32(32'h08, 32'hFFFF_FFFF, 1'b0, "post_rst_cmp");
    rd32(32'h10, 32'h0000_0000, 1'b0, "post_rst_ctrl");
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    repeat (2) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
